// File: rtl/huff_pkg.sv
// ============================================================================
// Module : huff_pkg
// Brief  : Shared types and code-table constants for the 3-symbol Huffman encoder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package huff_pkg;

  localparam int NUM_SYMS  = 3;
  localparam int FREQ_W    = 3;
  localparam int CHAR_W    = 8;
  localparam int CHAR_KEEP = 5;
  localparam int WIDX_W    = 3;

  localparam logic [2:0] CHAR_HI = 3'b011;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SORT  = 2'd1,
    ST_BUILD = 2'd2,
    ST_EMIT  = 2'd3
  } state_t;

  // Code bits are LSB-aligned; the mask marks which value bits are meaningful.
  localparam logic [1:0] MASK_R0 = 2'b01;
  localparam logic [1:0] VAL_R0  = 2'b00;
  localparam logic [1:0] MASK_R1 = 2'b11;
  localparam logic [1:0] VAL_R1  = 2'b10;
  localparam logic [1:0] MASK_R2 = 2'b11;
  localparam logic [1:0] VAL_R2  = 2'b11;

  localparam logic [WIDX_W-1:0] WIDX_DONE = 3'd6;

  function automatic logic [3:0] code_of(input logic [1:0] rank);
    case (rank)
      2'd0:    code_of = {MASK_R0, VAL_R0};
      2'd1:    code_of = {MASK_R1, VAL_R1};
      default: code_of = {MASK_R2, VAL_R2};
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/huff_rank3.sv
// ============================================================================
// Module : huff_rank3
// Brief  : Combinational 3-entry descending rank; ties rank the lower index first.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module huff_rank3
  import huff_pkg::*;
(
  input  logic [FREQ_W-1:0] freq0_i,
  input  logic [FREQ_W-1:0] freq1_i,
  input  logic [FREQ_W-1:0] freq2_i,
  output logic [1:0]        rank0_o,
  output logic [1:0]        rank1_o,
  output logic [1:0]        rank2_o
);

  // A slot's rank is the number of slots that beat it: a lower index wins on
  // equality, so it only needs >=, while a higher index needs strictly >.
  always_comb begin
    rank0_o = {1'b0, (freq1_i >  freq0_i)} + {1'b0, (freq2_i >  freq0_i)};
    rank1_o = {1'b0, (freq0_i >= freq1_i)} + {1'b0, (freq2_i >  freq1_i)};
    rank2_o = {1'b0, (freq0_i >= freq2_i)} + {1'b0, (freq1_i >= freq2_i)};
  end

endmodule

`default_nettype wire

// File: rtl/huff_encoder.sv
// ============================================================================
// Module : huff_encoder
// Brief  : Serial 3-symbol Huffman code generator; emits char/code word pairs.
//          Define HUFF_STATE_OUT_EN to drive the FSM state onto io_out[10:9].
// Rev    : 1.0
// ============================================================================
`default_nettype none

module huff_encoder
  import huff_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] io_in,
  output logic [11:0] io_out
);

  state_t                 state_q, state_d;
  logic [1:0]             cnt_q;
  logic [CHAR_KEEP-1:0]   char_q  [NUM_SYMS];
  logic [FREQ_W-1:0]      freq_q  [NUM_SYMS];
  logic [1:0]             rank_q  [NUM_SYMS];
  logic [1:0]             mask_q  [NUM_SYMS];
  logic [1:0]             value_q [NUM_SYMS];
  logic [WIDX_W-1:0]      widx_q;
  logic [8:0]             out_q, out_d;

  logic [1:0]             w_rank [NUM_SYMS];
  logic                   w_emit_done;
  logic                   w_cap;
  logic                   w_last;
  logic [1:0]             w_slot;
  logic                   w_unused_hi;

  assign w_unused_hi = ^io_in[7:5];
  assign w_emit_done = (state_q == ST_EMIT) && (widx_q == WIDX_DONE);
  // The edge that retires word5 already belongs to the next vector.
  assign w_cap       = io_in[11] && ((state_q == ST_LOAD) || w_emit_done);
  assign w_last      = w_cap && (state_q == ST_LOAD) && (cnt_q == 2'd2);
  assign w_slot      = widx_q[2:1];

  huff_rank3 u_rank (
    .freq0_i (freq_q[0]),
    .freq1_i (freq_q[1]),
    .freq2_i (freq_q[2]),
    .rank0_o (w_rank[0]),
    .rank1_o (w_rank[1]),
    .rank2_o (w_rank[2])
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_LOAD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD:  if (w_last) state_d = ST_SORT;
      ST_SORT:  state_d = ST_BUILD;
      ST_BUILD: state_d = ST_EMIT;
      ST_EMIT:  if (w_emit_done) state_d = ST_LOAD;
      default:  state_d = ST_LOAD;
    endcase
  end

  always_comb begin
    out_d = 9'h000;
    case (state_q)
      ST_BUILD: out_d = {1'b1, CHAR_HI, char_q[0]};
      ST_EMIT: begin
        if (!w_emit_done) begin
          if (widx_q[0]) out_d = {1'b1, 4'b0000, mask_q[w_slot], value_q[w_slot]};
          else           out_d = {1'b1, CHAR_HI, char_q[w_slot]};
        end
      end
      default: out_d = 9'h000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= 2'd0;
      widx_q <= '0;
      out_q  <= 9'h000;
      for (int i = 0; i < NUM_SYMS; i++) begin
        char_q[i]  <= '0;
        freq_q[i]  <= '0;
        rank_q[i]  <= 2'd0;
        mask_q[i]  <= 2'd0;
        value_q[i] <= 2'd0;
      end
    end else begin
      out_q <= out_d;
      if (w_cap) begin
        for (int i = 0; i < NUM_SYMS; i++) begin
          if (cnt_q == 2'(i)) begin
            char_q[i] <= io_in[CHAR_KEEP-1:0];
            freq_q[i] <= io_in[10:8];
          end
        end
        cnt_q <= w_last ? 2'd0 : cnt_q + 2'd1;
      end
      case (state_q)
        ST_SORT: begin
          for (int i = 0; i < NUM_SYMS; i++) rank_q[i] <= w_rank[i];
        end
        ST_BUILD: begin
          for (int i = 0; i < NUM_SYMS; i++) {mask_q[i], value_q[i]} <= code_of(rank_q[i]);
          widx_q <= 3'd1;
        end
        ST_EMIT: widx_q <= w_emit_done ? '0 : widx_q + 3'd1;
        default: ;
      endcase
    end
  end

`ifdef HUFF_STATE_OUT_EN
  assign io_out = {1'b0, state_q, out_q};
`else
  assign io_out = {3'b000, out_q};
`endif

endmodule

`default_nettype wire

// File: tb/tb_huff_encoder.sv
// ============================================================================
// Module : tb_huff_encoder
// Brief  : Directed vector bench for huff_encoder (optionally HUFF_STATE_OUT_EN).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_huff_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] io_in;
  logic [11:0] io_out;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef HUFF_STATE_OUT_EN
  localparam logic [11:0] EMIT_HI = 12'h600;
`else
  localparam logic [11:0] EMIT_HI = 12'h000;
`endif

  typedef struct packed {
    logic [2:0][7:0]  ch;
    logic [2:0][2:0]  fr;
    logic [5:0][11:0] w;
  } vec_t;

  vec_t tbl [3];

  huff_encoder dut (
    .clk    (clk),
    .reset  (reset),
    .io_in  (io_in),
    .io_out (io_out)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_sym(input logic [7:0] c, input logic [2:0] f);
    io_in = {1'b1, f, c};
    tick();
    io_in = 12'h000;
  endtask

  // Called right after the third capture edge.
  task automatic finish_vec(input vec_t v, input string tag, input bit pulse);
    int lat;
    if (pulse) io_in = {1'b1, 3'd7, 8'h7A};
    lat = 0;
    while (!io_out[8] && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 12'(lat), 12'd2);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("%s_word%0d", tag, k), io_out, v.w[k] | EMIT_HI);
      if (k < 5) tick();
    end
    io_in = 12'h000;
    tick();
    check({tag, "_idle"}, io_out, 12'h000);
  endtask

  task automatic run_vec(input vec_t v, input string tag, input bit pulse);
    for (int k = 0; k < 3; k++) send_sym(v.ch[k], v.fr[k]);
    finish_vec(v, tag, pulse);
  endtask

  initial begin
    tbl[0].ch = {8'h63, 8'h62, 8'h61};
    tbl[0].fr = {3'd1, 3'd2, 3'd5};
    tbl[0].w  = {12'h10F, 12'h163, 12'h10E, 12'h162, 12'h104, 12'h161};
    tbl[1].ch = {8'h63, 8'h62, 8'h61};
    tbl[1].fr = {3'd4, 3'd4, 3'd1};
    tbl[1].w  = {12'h10E, 12'h163, 12'h104, 12'h162, 12'h10F, 12'h161};
    tbl[2].ch = {8'h7A, 8'h79, 8'h78};
    tbl[2].fr = {3'd2, 3'd2, 3'd2};
    tbl[2].w  = {12'h10F, 12'h17A, 12'h10E, 12'h179, 12'h104, 12'h178};

    reset = 1'b1;
    io_in = 12'h000;
    tick();
    tick();
    check("reset_out", io_out, 12'h000);
    reset = 1'b0;
    tick();
    check("load_idle", io_out, 12'h000);

    for (int i = 0; i < 3; i++) run_vec(tbl[i], $sformatf("vec%0d", i), 1'b0);

    // Gapped valids, then valid pulses held through SORT/BUILD/EMIT.
    send_sym(tbl[0].ch[0], tbl[0].fr[0]);
    tick();
    tick();
    send_sym(tbl[0].ch[1], tbl[0].fr[1]);
    send_sym(tbl[0].ch[2], tbl[0].fr[2]);
    finish_vec(tbl[0], "gap", 1'b1);
    run_vec(tbl[2], "after_gap", 1'b0);

    // Asynchronous reset in the middle of EMIT.
    for (int k = 0; k < 3; k++) send_sym(tbl[1].ch[k], tbl[1].fr[k]);
    tick();
    tick();
    check("rst_word0", io_out, tbl[1].w[0] | EMIT_HI);
    tick();
    tick();
    check("rst_word2", io_out, tbl[1].w[2] | EMIT_HI);
    #2 reset = 1'b1;
    #1 check("rst_async", io_out, 12'h000);
    tick();
    reset = 1'b0;
    tick();
    check("rst_hold", io_out, 12'h000);
    run_vec(tbl[0], "after_rst", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/huff_encoder.md
Name: huff_encoder

Overview:
- Three-symbol Huffman code generator with a 12-bit in / 12-bit out pin interface.
- Accepts three (character, 3-bit frequency) pairs serially on io_in.
- Builds a Huffman code with lengths 1/2/2.
- Emits six 12-bit words: one character word and one code word per symbol, in input order.

Parameters:
- NUM_SYMS, 3, symbols per vector; only 3 is supported.
- FREQ_W, 3, frequency field width.
- CHAR_W, 8, character width on the pins. Stored internally as 5 bits.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- io_in  input  12  [11]=symbol valid, [10:8]=frequency (unsigned), [7:0]=ASCII character
- io_out  output  12  [11:9]=debug/zero, [8]=output valid, [7:0]=payload

Behaviour:
- One clock domain; reset is asynchronous and active-high.
- Reset values:
  - state=LOAD, symbol count=0.
  - io_out=12'h000.
  - All character, frequency, mask and value registers = 0.
- Characters must lie in 0x60..0x7F. Only bits [4:0] are stored; on output the character is rebuilt as {3'b011, char[4:0]}.
- States: LOAD(0), SORT(1), BUILD(2), EMIT(3).
- LOAD:
  - On each edge with io_in[11]=1, capture {freq, char} into slot count, then count++.
  - io_in[11]=0 leaves everything unchanged.
  - When the third symbol is captured (count was 2), reset count to 0 and go to SORT.
- SORT (1 cycle):
  - Rank symbols by frequency, descending.
  - Ties go to the lower input index, which ranks higher.
  - Register the rank of each slot. Go to BUILD.
- BUILD (1 cycle):
  - rank0: code "0", mask 2'b01, value 2'b00.
  - rank1: code "10", mask 2'b11, value 2'b10.
  - rank2: code "11", mask 2'b11, value 2'b11.
  - Values are LSB-aligned; mask marks the valid code bits.
  - Load io_out with word0. Go to EMIT with word index 1.
- EMIT:
  - io_out[8]=1 for exactly 6 consecutive cycles: words 0..5.
  - Word 2k: payload = {3'b011, char[k]}.
  - Word 2k+1: payload = {4'b0000, mask[k], value[k]}.
  - After word5 has been visible for one cycle, io_out returns to 0 and state returns to LOAD.
- Latency: third capture edge E; word0 is visible from E+2, and io_out[8] drops at E+8. The next symbol can be captured from edge E+8 onward.
- io_in[11] asserted during SORT, BUILD or EMIT is ignored (no capture, no queueing).
- Frequency 0 is legal and is ranked normally. All-equal frequencies produce the codes in index order.
- Reset asserted mid-operation aborts immediately; partial vectors are discarded.
- io_out[11:9]=0 unless the optional feature below is compiled in.

Optional Feature:
- Macro HUFF_STATE_OUT_EN.
- Defined: io_out[11:9] = {1'b0, state[1:0]} every cycle, including in LOAD.
- Undefined: io_out[11:9] is constant 0.
- io_out[8:0] is identical in both builds.

Decomposition:
- Package huff_pkg holds:
  - state enum (LOAD/SORT/BUILD/EMIT);
  - constants NUM_SYMS, FREQ_W, CHAR_HI=3'b011;
  - code table constants (mask/value per rank);
  - the output word index width.
- One sub-module, huff_rank3: a combinational 3-entry descending sort with lower-index tie-break, producing a 2-bit rank per slot.

Test Plan:
- Chars 'a','b','c', freqs 5,2,1 -> io_out words 0x161, 0x104, 0x162, 0x10E, 0x163, 0x10F on 6 consecutive cycles, starting 2 cycles after the third capture.
- Chars 'a','b','c', freqs 1,4,4 (tie) -> 'b' rank0 (0x104), 'c' rank1 (0x10E), 'a' rank2 (0x10F). Words: 0x161, 0x10F, 0x162, 0x104, 0x163, 0x10E.
- Chars 'x','y','z', freqs 2,2,2 -> 0x178, 0x104, 0x179, 0x10E, 0x17A, 0x10F.
- Valid-gap stimulus: symbols at cycles 0, 3, 4 with io_in[11]=0 between, plus io_in[11]=1 pulses held during EMIT -> the same six words as the first scenario, pulses ignored, and the next vector captured cleanly afterward.
- Reset asserted in EMIT after word 2 -> io_out=0 immediately (asynchronously), state LOAD; a following full vector emits all 6 correct words.
- Build with HUFF_STATE_OUT_EN: first scenario -> io_out[10:9]=2'b11 during all six valid words and 2'b00 while idle in LOAD.
